// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the digit-serial pipelined adder/subtractor.
package pipe_adder_pkg;

    // Default operand width and number of bits resolved per pipeline stage
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIGIT = 2;

    // Number of adding stages needed to sweep the whole operand
    function automatic int calc_stages(input int width, input int digit);
        return width / digit;
    endfunction

    // True when the operand splits into whole digits
    function automatic bit width_fits(input int width, input int digit);
        return (digit > 0) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit adder slice: one pipeline stage's worth of carry chain.
module adder_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] A,
    input  logic [DIGIT-1:0] B,
    input  logic             Ci,
    output logic [DIGIT-1:0] S,
    output logic             Co
);

    logic [DIGIT:0] total;

    // Widen by one bit so the carry out falls into the top position
    assign total = {1'b0, A} + {1'b0, B} + {{DIGIT{1'b0}}, Ci};
    assign S     = total[DIGIT-1:0];
    assign Co    = total[DIGIT];

endmodule

// File: rtl/pipe_adder_stream.sv
// Pipelined ripple-by-digit adder/subtractor with valid/ready flow control.
// Each stage adds one DIGIT-bit slice, so the critical path is one small add
// regardless of WIDTH. The whole pipe advances or holds together.
module pipe_adder_stream
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES = calc_stages(WIDTH, DIGIT);

    if (!width_fits(WIDTH, DIGIT)) begin : g_bad_params
        $error("pipe_adder_stream: WIDTH must be a non-zero multiple of DIGIT");
    end

    logic             adv;
    logic             accept;
    logic [STAGES:0]  valid_q;
    logic [WIDTH-1:0] y_cond;
    logic             c0;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] last_sum;
    logic             last_co;
    logic             last_x_sign;
    logic             last_y_sign;

    // Whole pipe moves when the output slot is empty or being drained
    assign adv      = !valid_q[STAGES] || Out_ready;
    assign In_ready = Rst_n && adv;
    assign accept   = In_valid && In_ready;

    // Subtraction is X + ~Y + ~Cin, so borrow-in becomes an inverted carry-in
    assign y_cond = Sub ? ~Y : Y;
    assign c0     = Sub ? ~Cin : Cin;

    // Stage i holds the operands before digit i is added. The X word keeps
    // its unconsumed upper digits in place while finished sum digits replace
    // the consumed ones from the bottom up; Y' shrinks as digits are used, so
    // its top bit (the conditioned sign) survives to the last stage.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int LO  = i * DIGIT;
        localparam int REM = WIDTH - LO;

        logic [WIDTH-1:0] acc;
        logic [REM-1:0]   y_rem;
        logic             carry;
        logic [DIGIT-1:0] dsum;
        logic             dco;
        logic [WIDTH-1:0] acc_next;

        adder_digit #(
            .DIGIT(DIGIT)
        ) u_digit (
            .A  (acc[LO +: DIGIT]),
            .B  (y_rem[DIGIT-1:0]),
            .Ci (carry),
            .S  (dsum),
            .Co (dco)
        );

        // Splice this stage's sum digit over the X digit it consumed
        always_comb begin
            acc_next           = acc;
            acc_next[LO +: DIGIT] = dsum;
        end

        if (i == 0) begin : g_first
            // Capture conditioned operands; contents of an empty slot are don't-care
            always_ff @(posedge Clk) begin
                if (adv) begin
                    acc   <= X;
                    y_rem <= y_cond;
                    carry <= c0;
                end
            end
        end else begin : g_next
            // Take the previous stage's partial result and remaining Y' digits
            always_ff @(posedge Clk) begin
                if (adv) begin
                    acc   <= g_stage[i-1].acc_next;
                    y_rem <= g_stage[i-1].y_rem[REM+DIGIT-1:DIGIT];
                    carry <= g_stage[i-1].dco;
                end
            end
        end
    end

    assign last_sum    = g_stage[STAGES-1].acc_next;
    assign last_co     = g_stage[STAGES-1].dco;
    assign last_x_sign = g_stage[STAGES-1].acc[WIDTH-1];
    assign last_y_sign = g_stage[STAGES-1].y_rem[DIGIT-1];

    // Valid shift vector and output register; outputs only change on a real beat
    // so they read zero from reset until the first result arrives
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            valid_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            valid_q <= {valid_q[STAGES-1:0], accept};
            if (valid_q[STAGES-1]) begin
                sum_q  <= last_sum;
                cout_q <= last_co;
                ovf_q  <= (last_x_sign == last_y_sign) && (last_sum[WIDTH-1] != last_x_sign);
            end
        end
    end

    assign Out_valid = valid_q[STAGES];
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder_stream.sv
// Scoreboard bench for pipe_adder_stream: an 8-bit/2-bit instance and a
// 12-bit/3-bit instance, each checked against an integer-arithmetic model.
module tb_pipe_adder_stream;

    typedef struct {
        logic [11:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk;

    logic        rst_n8, in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  x8, y8, sum8;
    logic        rst_n12, in_valid12, in_ready12, cin12, sub12, out_valid12, out_ready12, cout12, ovf12;
    logic [11:0] x12, y12, sum12;

    int checks   = 0;
    int failures = 0;

    exp_t q8[$];
    exp_t q12[$];
    exp_t e8, e12;
    bit          stall8 = 0, stall12 = 0;
    logic [10:0] held8;
    logic [14:0] held12;

    pipe_adder_stream #(.WIDTH(8), .DIGIT(2)) u_dut8 (
        .Clk(clk), .Rst_n(rst_n8), .In_valid(in_valid8), .In_ready(in_ready8),
        .X(x8), .Y(y8), .Cin(cin8), .Sub(sub8),
        .Out_valid(out_valid8), .Out_ready(out_ready8),
        .Sum(sum8), .Cout(cout8), .Ovf(ovf8)
    );

    pipe_adder_stream #(.WIDTH(12), .DIGIT(3)) u_dut12 (
        .Clk(clk), .Rst_n(rst_n12), .In_valid(in_valid12), .In_ready(in_ready12),
        .X(x12), .Y(y12), .Cin(cin12), .Sub(sub12),
        .Out_valid(out_valid12), .Out_ready(out_ready12),
        .Sum(sum12), .Cout(cout12), .Ovf(ovf12)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result from plain signed/unsigned integer arithmetic
    function automatic exp_t model(input int w, input longint x, input longint y,
                                   input bit cin, input bit sub);
        exp_t   e;
        longint m  = longint'(1) << w;
        longint h  = m / 2;
        longint r  = sub ? (x - y - cin) : (x + y + cin);
        longint sx = (x >= h) ? x - m : x;
        longint sy = (y >= h) ? y - m : y;
        longint sr = sub ? (sx - sy - cin) : (sx + sy + cin);
        longint s  = ((r % m) + m) % m;
        e.sum  = 12'(s);
        e.cout = sub ? (r >= 0) : (r >= m);
        e.ovf  = (sr < -h) || (sr > h - 1);
        return e;
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // 8-bit monitor: flush on reset, check holds under stall, score results, log accepts
    always @(negedge clk) begin
        if (!rst_n8) begin
            q8.delete();
            stall8 = 0;
        end else begin
            if (stall8)
                checkOutput("hold8", {out_valid8, sum8, cout8, ovf8}, held8);
            stall8 = out_valid8 && !out_ready8;
            held8  = {out_valid8, sum8, cout8, ovf8};
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    checkOutput("unexpected_out8", 32'(q8.size()), 1);
                end else begin
                    e8 = q8.pop_front();
                    checkOutput("result8", {sum8, cout8, ovf8}, {e8.sum[7:0], e8.cout, e8.ovf});
                end
            end
            if (in_valid8 && in_ready8)
                q8.push_back(model(8, longint'(x8), longint'(y8), cin8, sub8));
        end
    end

    // 12-bit monitor, same scoring rules
    always @(negedge clk) begin
        if (!rst_n12) begin
            q12.delete();
            stall12 = 0;
        end else begin
            if (stall12)
                checkOutput("hold12", {out_valid12, sum12, cout12, ovf12}, held12);
            stall12 = out_valid12 && !out_ready12;
            held12  = {out_valid12, sum12, cout12, ovf12};
            if (out_valid12 && out_ready12) begin
                if (q12.size() == 0) begin
                    checkOutput("unexpected_out12", 32'(q12.size()), 1);
                end else begin
                    e12 = q12.pop_front();
                    checkOutput("result12", {sum12, cout12, ovf12}, {e12.sum, e12.cout, e12.ovf});
                end
            end
            if (in_valid12 && in_ready12)
                q12.push_back(model(12, longint'(x12), longint'(y12), cin12, sub12));
        end
    end

    // Send one beat with the consumer always ready and measure its latency
    task automatic applyStimulus(input bit wide, input logic [11:0] x, input logic [11:0] y,
                                 input bit cin, input bit sub);
        int lat;
        @(posedge clk); #1;
        if (wide) begin
            x12 = x; y12 = y; cin12 = cin; sub12 = sub; in_valid12 = 1'b1; out_ready12 = 1'b1;
        end else begin
            x8 = x[7:0]; y8 = y[7:0]; cin8 = cin; sub8 = sub; in_valid8 = 1'b1; out_ready8 = 1'b1;
        end
        #1 checkOutput(wide ? "accept_ready12" : "accept_ready8", wide ? in_ready12 : in_ready8, 1);
        @(posedge clk); #1;
        in_valid8  = 1'b0;
        in_valid12 = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (wide ? out_valid12 : out_valid8) break;
        end
        checkOutput(wide ? "latency12" : "latency8", lat, 4);
    endtask

    // Wait for the scoreboard to empty, then confirm nothing extra appears
    task automatic drain(input bit wide);
        int n = 0;
        in_valid8 = 1'b0; in_valid12 = 1'b0; out_ready8 = 1'b1; out_ready12 = 1'b1;
        while (n < 100 && (wide ? q12.size() : q8.size()) != 0) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1 checkOutput(wide ? "drain12" : "drain8", 32'(wide ? q12.size() : q8.size()), 0);
    endtask

    // 20 back-to-back random beats with a 3-cycle consumer stall mid-stream
    task automatic streamWithStall();
        int sent = 0;
        int cyc  = 0;
        logic [7:0] nx = 8'($urandom), ny = 8'($urandom);
        bit nc = 1'($urandom), ns = 1'($urandom);
        while (sent < 20 && cyc < 200) begin
            @(posedge clk); #1;
            out_ready8 = !(cyc >= 8 && cyc < 11);
            x8 = nx; y8 = ny; cin8 = nc; sub8 = ns; in_valid8 = 1'b1;
            #1;
            if (cyc >= 8 && cyc < 11)
                checkOutput("stall_in_ready8", in_ready8, 0);
            if (in_ready8) begin
                sent++;
                nx = 8'($urandom); ny = 8'($urandom); nc = 1'($urandom); ns = 1'($urandom);
            end
            cyc++;
        end
        checkOutput("stream_sent8", sent, 20);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
    endtask

    // Random beats and random back-pressure on the 12-bit instance
    task automatic randomStream12(input int beats);
        int  sent = 0;
        int  cyc  = 0;
        bit  took = 1;
        while (sent < beats && cyc < 20000) begin
            @(posedge clk); #1;
            out_ready12 = ($urandom_range(0, 3) != 0);
            if (took || !in_valid12) begin
                in_valid12 = ($urandom_range(0, 3) != 0);
                x12 = 12'($urandom); y12 = 12'($urandom);
                cin12 = 1'($urandom); sub12 = 1'($urandom);
            end
            #1;
            took = in_valid12 && in_ready12;
            if (took) sent++;
            cyc++;
        end
        checkOutput("random_sent12", sent, beats);
        @(posedge clk); #1;
        in_valid12 = 1'b0;
    endtask

    // Hard stop if anything above stops making progress
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        rst_n8 = 1'b0; in_valid8 = 1'b1; x8 = 8'h5A; y8 = 8'h33; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        rst_n12 = 1'b0; in_valid12 = 1'b0; x12 = '0; y12 = '0; cin12 = 1'b0; sub12 = 1'b0; out_ready12 = 1'b1;

        // Reset held three cycles with a beat offered
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready8", in_ready8, 0);
        checkOutput("reset_out_valid8", out_valid8, 0);
        checkOutput("reset_sum8", sum8, 0);
        checkOutput("reset_cout8", cout8, 0);
        checkOutput("reset_ovf8", ovf8, 0);
        @(posedge clk); #1;
        rst_n8 = 1'b1;
        in_valid8 = 1'b0;
        #1 checkOutput("post_reset_in_ready8", in_ready8, 1);
        repeat (8) @(posedge clk);
        #1 checkOutput("post_reset_idle8", out_valid8, 0);

        // Directed add/subtract corners
        applyStimulus(0, 12'h0FF, 12'h001, 0, 0);
        applyStimulus(0, 12'h07F, 12'h001, 0, 0);
        applyStimulus(0, 12'h005, 12'h007, 0, 1);
        applyStimulus(0, 12'h080, 12'h001, 0, 1);
        applyStimulus(0, 12'h000, 12'h000, 1, 1);
        applyStimulus(0, 12'h080, 12'h080, 1, 0);
        drain(0);

        streamWithStall();
        drain(0);

        // Reset while three beats are in flight: none may emerge
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            x8 = 8'($urandom); y8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
            in_valid8 = 1'b1;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        rst_n8 = 1'b0;
        @(posedge clk); #1;
        checkOutput("midflight_reset_valid8", out_valid8, 0);
        rst_n8 = 1'b1;
        repeat (8) @(posedge clk);
        #1 checkOutput("midflight_no_output8", out_valid8, 0);
        applyStimulus(0, 12'h0C3, 12'h05A, 1, 0);
        drain(0);

        // Wider instance with a 3-bit digit
        @(posedge clk); #1;
        rst_n12 = 1'b1;
        applyStimulus(1, 12'hFFF, 12'h001, 1, 0);
        applyStimulus(1, 12'h800, 12'h001, 0, 1);
        drain(1);
        randomStream12(1000);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
